// File: rtl/stack_arb2.sv
// Two-port round-robin arbiter wrapped around a shared 8-entry LIFO stack.
// Grants are combinational; pop data, error pulses and occupancy are registered.
module stack_arb2 #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          op0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          op1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic [3:0]    count,
  output logic          empty,
  output logic          full
);

  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  logic [3:0]    count_q,   count_d;
  logic          last_q,    last_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          err0_q,    err0_d;
  logic          err1_q,    err1_d;
  logic          empty_q,   empty_d;
  logic          full_q,    full_d;

  logic          gnt0_s, gnt1_s;
  logic          op_s;
  logic [DW-1:0] wdata_s;
  logic [2:0]    push_idx_s, pop_idx_s;
  logic          is_full_s, is_empty_s;
  logic          mem_we_s;

  // Round-robin arbitration: under contention the requester that did not go last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case ({req0, req1})
      2'b10: gnt0_s = 1'b1;
      2'b01: gnt1_s = 1'b1;
      2'b11: begin
        if (last_q) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  // Operand mux and stack pointer decode for the granted requester.
  always_comb begin
    if (gnt1_s) begin
      op_s    = op1;
      wdata_s = wdata1;
    end else begin
      op_s    = op0;
      wdata_s = wdata0;
    end
    // count never exceeds 8; at 8 the low bits are 0 and 0-1 wraps to index 7.
    push_idx_s = count_q[2:0];
    pop_idx_s  = count_q[2:0] - 3'd1;
    is_full_s  = (count_q == FULL_CNT);
    is_empty_s = (count_q == 4'd0);
  end

  // Next-state: execute the granted push/pop or flag it as rejected.
  always_comb begin
    count_d   = count_q;
    last_d    = last_q;
    rdata_d   = rdata_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    mem_we_s  = 1'b0;
    if (gnt0_s || gnt1_s) begin
      last_d = gnt1_s;
      if (op_s) begin
        if (is_full_s) begin
          err0_d = gnt0_s;
          err1_d = gnt1_s;
        end else begin
          mem_we_s = 1'b1;
          count_d  = count_q + 4'd1;
        end
      end else begin
        if (is_empty_s) begin
          err0_d = gnt0_s;
          err1_d = gnt1_s;
        end else begin
          rdata_d   = mem_q[pop_idx_s];
          count_d   = count_q - 4'd1;
          rvalid0_d = gnt0_s;
          rvalid1_d = gnt1_s;
        end
      end
    end else begin
      last_d = last_q;
    end
    empty_d = (count_d == 4'd0);
    full_d  = (count_d == FULL_CNT);
  end

  // Control and status registers; requester 0 wins the first contention after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= 4'd0;
      last_q    <= 1'b1;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      last_q    <= last_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
    end
  end

  // Stack storage; never read before written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[push_idx_s] <= wdata_s;
    end
  end

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata   = rdata_q;
  assign count   = count_q;
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: tb/tb_stack_arb2.sv
// Table-driven bench for stack_arb2: each vector's post-edge expectation goes
// through a scoreboard queue and is compared once the DUT has clocked it.
module tb_stack_arb2;

  typedef struct packed {
    logic       r0;
    logic       o0;
    logic [7:0] w0;
    logic       r1;
    logic       o1;
    logic [7:0] w1;
    logic       g0;
    logic       g1;
    logic       rv0;
    logic       rv1;
    logic       e0;
    logic       e1;
    logic [7:0] rd;
    logic [3:0] cnt;
  } vec_t;

  typedef struct packed {
    logic       rv0;
    logic       rv1;
    logic       e0;
    logic       e1;
    logic [7:0] rd;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, rvalid0, rvalid1, err0, err1, empty, full;
  logic [7:0] rdata;
  logic [3:0] count;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs_a[$];
  vec_t vecs_b[$];
  exp_t sb[$];

  stack_arb2 #(.DW(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .wdata0(wdata0),
    .req1(req1), .op1(op1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .err0(err0), .err1(err1),
    .rdata(rdata), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic o0, input logic [7:0] w0,
                              input logic r1, input logic o1, input logic [7:0] w1,
                              input logic g0, input logic g1,
                              input logic rv0, input logic rv1, input logic e0, input logic e1,
                              input logic [7:0] rd, input logic [3:0] cnt);
    vec_t v;
    v = '{r0:r0, o0:o0, w0:w0, r1:r1, o1:o1, w1:w1, g0:g0, g1:g1,
          rv0:rv0, rv1:rv1, e0:e0, e1:e1, rd:rd, cnt:cnt};
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    req0 = v.r0; op0 = v.o0; wdata0 = v.w0;
    req1 = v.r1; op1 = v.o1; wdata1 = v.w1;
    sb.push_back('{rv0:v.rv0, rv1:v.rv1, e0:v.e0, e1:v.e1, rd:v.rd, cnt:v.cnt});
    #1;
    chk($sformatf("gnt0[%0d]", idx), 32'(gnt0), 32'(v.g0));
    chk($sformatf("gnt1[%0d]", idx), 32'(gnt1), 32'(v.g1));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("rvalid0[%0d]", idx), 32'(rvalid0), 32'(e.rv0));
    chk($sformatf("rvalid1[%0d]", idx), 32'(rvalid1), 32'(e.rv1));
    chk($sformatf("err0[%0d]", idx), 32'(err0), 32'(e.e0));
    chk($sformatf("err1[%0d]", idx), 32'(err1), 32'(e.e1));
    chk($sformatf("rdata[%0d]", idx), 32'(rdata), 32'(e.rd));
    chk($sformatf("count[%0d]", idx), 32'(count), 32'(e.cnt));
    chk($sformatf("empty[%0d]", idx), 32'(empty), 32'(e.cnt == 4'd0));
    chk($sformatf("full[%0d]", idx), 32'(full), 32'(e.cnt == 4'd8));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase A: fill, overflow, drain, underflow, push/pop, contention, drop.
    for (int i = 0; i < 8; i++)
      vecs_a.push_back(mk(1'b1, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 8'h00,
                          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'(i + 1)));
    vecs_a.push_back(mk(1'b1, 1'b1, 8'h19, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd8));
    for (int i = 0; i < 8; i++)
      vecs_a.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,
                          1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h18 - i), 4'(7 - i)));
    vecs_a.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'd0));
    vecs_a.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 4'd1));
    vecs_a.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 4'd0));
    vecs_a.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 4'd1));
    vecs_a.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 4'd2));
    vecs_a.push_back(mk(1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 4'd3));
    vecs_a.push_back(mk(1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA0, 4'd2));
    vecs_a.push_back(mk(1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 4'd3));
    vecs_a.push_back(mk(1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA0, 4'd2));
    vecs_a.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 4'd1));
    vecs_a.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 4'd2));
    vecs_a.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 4'd1));
    for (int i = 0; i < 5; i++)
      vecs_a.push_back(mk(1'b1, 1'b1, 8'(8'h88 + 8'h11 * i), 1'b0, 1'b0, 8'h00,
                          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 4'(i + 2)));
    vecs_a.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCC, 4'd5));

    // Phase B: after a mid-stream reset requester 0 must win first.
    vecs_b.push_back(mk(1'b1, 1'b1, 8'hC1, 1'b1, 1'b1, 8'hC2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1));
    vecs_b.push_back(mk(1'b1, 1'b1, 8'hC1, 1'b1, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd2));
    vecs_b.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC2, 4'd1));
    vecs_b.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC1, 4'd0));
    vecs_b.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC1, 4'd0));

    // Reset and idle state.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("reset_pulses", 32'({rvalid0, rvalid1, err0, err1}), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);

    for (int i = 0; i < vecs_a.size(); i++) apply(vecs_a[i], i);

    // rvalid0 is high here with count 5; reset between edges must clear it at once.
    chk("pre_rst_rvalid0", 32'(rvalid0), 32'd1);
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b1; wdata0 = 8'hBB;
    req1 = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("async_rst_rdata", 32'(rdata), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_lost_op_count", 32'(count), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < vecs_b.size(); i++) apply(vecs_b[i], 100 + i);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_arb2.md
# stack_arb2

Two-port arbiter and controller for the shared 8-entry hardware stack. It accepts push/pop requests from two independent requesters and grants at most one operation per cycle using round-robin priority. It owns the stack pointer and storage, and returns pop data and error status to the requester that issued the operation. It sits between the two client engines and the stack storage, replacing direct push/pop wiring when the stack is shared.

## Interface
Parameters:
- DW, 8, data word width
- DEPTH, 8, stack entries; fixed at 8, pointer/count width 4

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- req0 / req1  input  1  request from requester 0 / 1; held until granted
- op0 / op1  input  1  operation: 1 = push, 0 = pop; stable while req high
- wdata0 / wdata1  input  DW  push data; stable while req high
- gnt0 / gnt1  output  1  combinational grant; operation executes at the edge ending the grant cycle
- rvalid0 / rvalid1  output  1  registered one-cycle pulse: pop data on rdata is valid for that requester
- err0 / err1  output  1  registered one-cycle pulse: granted operation rejected (push when full, pop when empty)
- rdata  output  DW  registered pop data, shared by both requesters
- count  output  4  registered number of occupied entries, 0..8
- empty  output  1  count == 0
- full  output  1  count == 8

## Operation
- State: count[3:0], last[0] (index of last granted requester), mem[0..7] x DW, rdata, rvalid0/1, err0/1.
- Reset (rst low, asynchronous): count=0, last=1 (requester 0 wins first contention), rdata=0, rvalid0/1=0, err0/1=0. gnt0/1=0 follow from req low. mem is not reset; it is never read before being written.
- Arbitration, combinational:
  - only req0 -> gnt0
  - only req1 -> gnt1
  - both -> grant requester != last
  - neither -> no grant
  - gnt0 & gnt1 never both 1.
- On the edge ending a grant cycle for requester i:
  - last <= i.
  - Push, not full: mem[count] <= wdata_i, count <= count+1.
  - Pop, not empty: rdata <= mem[count-1], count <= count-1, rvalid_i <= 1.
  - Push when full or pop when empty: count, mem and rdata unchanged; err_i <= 1.
- rvalid_i and err_i are cleared on any edge without a qualifying grant. rdata holds its last value otherwise.
- The losing requester keeps req high and wins the next cycle if the winner also requests again (strict alternation under contention).
- A requester may drop req before being granted; no operation and no side effect result.
- Single requester with req held high is granted every cycle: back-to-back operations, one per clock.
- Pointer arithmetic is unsigned 4-bit; count never leaves 0..8, so no wrap-around.

## Timing
- Grant latency: 0 cycles (gnt is combinational from req, last).
- State update: same edge that ends the grant cycle; count/empty/full reflect it in the next cycle.
- Pop data latency: rdata and rvalid_i valid 1 cycle after the grant cycle, for exactly 1 cycle.
- Error latency: err_i high 1 cycle after the grant cycle, for exactly 1 cycle. rvalid_i and err_i are never both high.
- Push followed by pop in the next cycle, from either requester, returns the just-pushed word.
- rst asserted mid-operation clears everything immediately regardless of clk. The operation granted in that cycle is lost. First grant is possible in the first cycle after rst deasserts.

## Test plan
- Reset then idle -> count=0, empty=1, full=0, gnt0/1=0, rvalid/err=0, rdata=0.
- req0 pushes 0x11..0x18 back-to-back (8 cycles) -> count steps 1..8, full=1. Ninth push -> gnt0=1, err0 pulses, count stays 8.
- Both requesters hold req continuously, req0 push 0xA0, req1 pop, starting from count=2 with top 0x55 -> grants alternate 0,1,0,1. Each pop gives rvalid1 pulse with the most recent pushed value (first 0xA0). count oscillates 3,2,3,2.
- From empty, req1 pops -> err1 pulses one cycle later, rvalid1=0, count=0. Then req1 pushes 0x3C and pops next cycle -> rdata=0x3C with rvalid1, count returns 0.
- req0 drops req after losing arbitration to req1 -> only req1's operation occurs, no err0/rvalid0.
- rst pulsed low mid-stream at count=5 between clock edges -> count=0, empty=1, all pulses cleared immediately. After release, both requesting -> gnt0 first.
